// File: rtl/softex_slot_ctrl_if.sv
// Purpose : bundle of the slot controller's request, response, update, memory and status signals.
// Latency : none, wires only.
// Backpr. : carried by req_ready_o / upd_ready_o; responses have no backpressure.
// Ports   : requester side (req_*, resp_*), datapath write-back side (upd_*),
//           single-port slot memory side (mem_*), occupancy status (free_cnt_o).
//           The controller connects through 'slave'; the environment drives through 'master'.
`timescale 1ns/1ps
interface softex_slot_ctrl_if #(
  parameter int N_REQ   = 2,
  parameter int N_SLOTS = 16,
  parameter int ADDR_W  = 8,
  parameter int SLOT_DW = 192
);
  localparam int OP_W  = 1 + ADDR_W;
  localparam int CNT_W = $clog2(N_SLOTS + 1);

  // requester side: per requester {op: ALLOC=0/LOAD=1, addr}
  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic [N_REQ*OP_W-1:0]   req_op_i;
  logic [N_REQ-1:0]        resp_valid_o;
  logic                    resp_fail_o;
  logic [ADDR_W-1:0]       resp_addr_o;
  logic [SLOT_DW-1:0]      resp_data_o;

  // datapath write-back side: {op: UPDATE=0/FREE=1, addr, data}
  logic                        upd_valid_i;
  logic                        upd_ready_o;
  logic [ADDR_W+SLOT_DW:0]     upd_op_i;

  // slot memory side, read data one cycle after a read strobe
  logic                    mem_req_o;
  logic                    mem_we_o;
  logic [ADDR_W-1:0]       mem_addr_o;
  logic [SLOT_DW-1:0]      mem_wdata_o;
  logic [SLOT_DW-1:0]      mem_rdata_i;

  logic [CNT_W-1:0]        free_cnt_o;

  modport slave (
    input  req_valid_i, req_op_i, upd_valid_i, upd_op_i, mem_rdata_i,
    output req_ready_o, resp_valid_o, resp_fail_o, resp_addr_o, resp_data_o,
    output upd_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, free_cnt_o
  );

  modport master (
    output req_valid_i, req_op_i, upd_valid_i, upd_op_i, mem_rdata_i,
    input  req_ready_o, resp_valid_o, resp_fail_o, resp_addr_o, resp_data_o,
    input  upd_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, free_cnt_o
  );
endinterface

// File: rtl/softex_slot_ctrl.sv
// Purpose : sequences the shared softex slot store (per-row running max/denominator); round-robin
//           arbitrates ALLOC/LOAD requesters, serialises UPDATE/FREE write-backs, tracks occupancy.
// Latency : ALLOC / failed LOAD respond at T+1, LOAD hit at T+2, UPDATE/FREE bitmap effective at T+1.
// Backpr. : ready only in IDLE, updates win over requests; responses are a 1-cycle strobe, no backpressure.
// Ports   : clk_i, rst_i (async, active-high) and the 'bus' interface (slave modport) carrying
//           req_*/resp_* (requesters), upd_* (datapath), mem_* (single-port slot memory), free_cnt_o.
`timescale 1ns/1ps
module softex_slot_ctrl #(
  parameter int N_REQ   = 2,
  parameter int N_SLOTS = 16,
  parameter int ADDR_W  = 8,
  parameter int SLOT_DW = 192
) (
  input  logic                clk_i,
  input  logic                rst_i,
  softex_slot_ctrl_if.slave   bus
);

  localparam int OP_W    = 1 + ADDR_W;
  localparam int RR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SLOT_IW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int CNT_W   = $clog2(N_SLOTS + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] RESP    = 2'd2;

  localparam logic OP_ALLOC  = 1'b0;
  localparam logic OP_UPDATE = 1'b0;

  // state
  logic [1:0]         state_q,  state_d;
  logic [N_SLOTS-1:0] bitmap_q, bitmap_d;
  logic [RR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [RR_W-1:0]    winner_q, winner_d;
  logic               fail_q,   fail_d;
  logic [ADDR_W-1:0]  raddr_q,  raddr_d;
  logic [SLOT_DW-1:0] rdata_q,  rdata_d;

  // update decode
  logic               upd_kind;
  logic [ADDR_W-1:0]  upd_addr;
  logic [SLOT_DW-1:0] upd_data;
  logic               upd_in_range;

  assign upd_kind     = bus.upd_op_i[ADDR_W+SLOT_DW];
  assign upd_addr     = bus.upd_op_i[SLOT_DW +: ADDR_W];
  assign upd_data     = bus.upd_op_i[SLOT_DW-1:0];
  assign upd_in_range = int'(upd_addr) < N_SLOTS;

  // round-robin arbiter: first valid requester at or after rr_ptr, cyclic
  logic            grant_vld;
  logic [RR_W-1:0] grant_idx;
  int              cand;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (int'(rr_ptr_q) + i) % N_REQ;
      if (!grant_vld && bus.req_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = RR_W'(cand);
      end
    end
  end

  // winner's request decode
  logic [OP_W-1:0]   sel_op;
  logic              req_kind;
  logic [ADDR_W-1:0] req_addr;
  logic              req_in_range;
  logic              load_hit;

  assign sel_op       = bus.req_op_i[int'(grant_idx)*OP_W +: OP_W];
  assign req_kind     = sel_op[OP_W-1];
  assign req_addr     = sel_op[ADDR_W-1:0];
  assign req_in_range = int'(req_addr) < N_SLOTS;
  assign load_hit     = req_in_range && bitmap_q[req_addr[SLOT_IW-1:0]];

  // lowest-index clear bit for ALLOC
  logic               free_vld;
  logic [SLOT_IW-1:0] free_slot;

  always_comb begin
    free_vld  = 1'b0;
    free_slot = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (!free_vld && !bitmap_q[i]) begin
        free_vld  = 1'b1;
        free_slot = SLOT_IW'(i);
      end
    end
  end

  // occupancy count, straight from the bitmap so it reads N_SLOTS during reset
  logic [CNT_W-1:0] free_cnt;

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (!bitmap_q[i]) free_cnt = free_cnt + CNT_W'(1);
    end
  end

  // next state and the combinational handshake / memory outputs
  logic [N_REQ-1:0]   req_ready;
  logic               upd_ready;
  logic               mem_req;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [SLOT_DW-1:0] mem_wdata;

  always_comb begin
    state_d   = state_q;
    bitmap_d  = bitmap_q;
    rr_ptr_d  = rr_ptr_q;
    winner_d  = winner_q;
    fail_d    = fail_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    req_ready = '0;
    upd_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      IDLE: begin
        // the handshake outputs are combinational from inputs, so hold them off during reset
        if (!rst_i) begin
          if (bus.upd_valid_i) begin
            upd_ready = 1'b1;
            // out-of-range updates are consumed silently
            if (upd_in_range) begin
              if (upd_kind == OP_UPDATE) begin
                bitmap_d[upd_addr[SLOT_IW-1:0]] = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = upd_addr;
                mem_wdata = upd_data;
              end else begin
                bitmap_d[upd_addr[SLOT_IW-1:0]] = 1'b0;
              end
            end
          end else if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
            rr_ptr_d = RR_W'((int'(grant_idx) + 1) % N_REQ);
            winner_d = grant_idx;
            rdata_d  = '0;
            if (req_kind == OP_ALLOC) begin
              fail_d  = !free_vld;
              raddr_d = free_vld ? ADDR_W'(free_slot) : '0;
              if (free_vld) bitmap_d[free_slot] = 1'b1;
              state_d = RESP;
            end else begin
              raddr_d = req_addr;
              if (load_hit) begin
                fail_d   = 1'b0;
                mem_req  = 1'b1;
                mem_addr = req_addr;
                state_d  = RD_WAIT;
              end else begin
                fail_d  = 1'b1;
                state_d = RESP;
              end
            end
          end
        end
      end
      RD_WAIT: begin
        rdata_d = bus.mem_rdata_i;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      bitmap_q <= '0;
      rr_ptr_q <= '0;
      winner_q <= '0;
      fail_q   <= 1'b0;
      raddr_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      bitmap_q <= bitmap_d;
      rr_ptr_q <= rr_ptr_d;
      winner_q <= winner_d;
      fail_q   <= fail_d;
      raddr_q  <= raddr_d;
      rdata_q  <= rdata_d;
    end
  end

  // response fields are only meaningful in RESP and read as zero otherwise
  logic             in_resp;
  logic [N_REQ-1:0] resp_valid;

  assign in_resp = (state_q == RESP);

  always_comb begin
    resp_valid = '0;
    for (int r = 0; r < N_REQ; r++) begin
      resp_valid[r] = in_resp && (winner_q == RR_W'(r));
    end
  end

  assign bus.req_ready_o  = req_ready;
  assign bus.upd_ready_o  = upd_ready;
  assign bus.resp_valid_o = resp_valid;
  assign bus.resp_fail_o  = in_resp && fail_q;
  assign bus.resp_addr_o  = in_resp ? raddr_q : '0;
  assign bus.resp_data_o  = in_resp ? rdata_q : '0;
  assign bus.mem_req_o    = mem_req;
  assign bus.mem_we_o     = mem_we;
  assign bus.mem_addr_o   = mem_addr;
  assign bus.mem_wdata_o  = mem_wdata;
  assign bus.free_cnt_o   = free_cnt;

endmodule

// File: tb/tb_softex_slot_ctrl.sv
// Purpose : self-checking bench for softex_slot_ctrl with a slot-level reference model and a
//           behavioural single-port memory with 1-cycle read latency.
// Flow    : directed scenarios (alloc, update/load, full, round-robin, priority, reset) then random ops.
`timescale 1ns/1ps
module tb_softex_slot_ctrl;
  localparam int N_REQ   = 2;
  localparam int N_SLOTS = 16;
  localparam int ADDR_W  = 8;
  localparam int SLOT_DW = 192;
  localparam int OP_W    = 1 + ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  softex_slot_ctrl_if #(.N_REQ(N_REQ), .N_SLOTS(N_SLOTS), .ADDR_W(ADDR_W), .SLOT_DW(SLOT_DW)) bus();

  softex_slot_ctrl #(.N_REQ(N_REQ), .N_SLOTS(N_SLOTS), .ADDR_W(ADDR_W), .SLOT_DW(SLOT_DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // slot memory
  logic [SLOT_DW-1:0] mem [256];
  always @(posedge clk) begin
    if (bus.mem_req_o && bus.mem_we_o)  mem[bus.mem_addr_o] <= bus.mem_wdata_o;
    if (bus.mem_req_o && !bus.mem_we_o) bus.mem_rdata_i <= mem[bus.mem_addr_o];
  end

  // reference model: occupancy set, last data written per address, round-robin pointer
  bit                 m_bm [N_SLOTS];
  logic [SLOT_DW-1:0] m_dat [256];
  int                 m_rr;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [SLOT_DW-1:0] obs, input logic [SLOT_DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_first_free();
    for (int i = 0; i < N_SLOTS; i++) if (!m_bm[i]) return i;
    return -1;
  endfunction

  function automatic int m_free_cnt();
    int c = 0;
    for (int i = 0; i < N_SLOTS; i++) if (!m_bm[i]) c++;
    return c;
  endfunction

  function automatic bit m_hit(input logic [ADDR_W-1:0] a);
    return (int'(a) < N_SLOTS) && m_bm[int'(a)];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N_SLOTS; i++) m_bm[i] = 1'b0;
    m_rr = 0;
  endtask

  // predicted response for an accepted request; updates the model
  task automatic predict(input int r, input bit op, input logic [ADDR_W-1:0] a,
                         output int lat, output bit efail, output logic [ADDR_W-1:0] eaddr,
                         output logic [SLOT_DW-1:0] edat);
    int idx;
    m_rr = (r + 1) % N_REQ;
    if (op == 1'b0) begin
      idx   = m_first_free();
      efail = (idx < 0);
      eaddr = efail ? '0 : ADDR_W'(idx);
      edat  = '0;
      lat   = 1;
      if (!efail) m_bm[idx] = 1'b1;
    end else begin
      efail = !m_hit(a);
      eaddr = a;
      edat  = efail ? '0 : m_dat[a];
      lat   = efail ? 1 : 2;
    end
  endtask

  task automatic do_req(input int r, input bit op, input logic [ADDR_W-1:0] a);
    int lat; bit efail; logic [ADDR_W-1:0] eaddr; logic [SLOT_DW-1:0] edat;
    int k; bit hit;
    @(posedge clk); #1;
    bus.req_valid_i = '0;
    bus.req_valid_i[r] = 1'b1;
    bus.req_op_i[r*OP_W +: OP_W] = {op, a};
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.req_ready_o[r] && k < 20);
    hit = op && m_hit(a);
    check("req_grant", SLOT_DW'(bus.req_ready_o), SLOT_DW'(1 << r));
    check("req_mem_read", SLOT_DW'({bus.mem_req_o, bus.mem_we_o}), SLOT_DW'({hit, 1'b0}));
    if (hit) check("req_mem_addr", SLOT_DW'(bus.mem_addr_o), SLOT_DW'(a));
    predict(r, op, a, lat, efail, eaddr, edat);
    @(posedge clk); #1;
    bus.req_valid_i[r] = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c < lat) begin
        check("resp_early", SLOT_DW'(bus.resp_valid_o), '0);
      end else begin
        check("resp_valid", SLOT_DW'(bus.resp_valid_o), SLOT_DW'(1 << r));
        check("resp_fail",  SLOT_DW'(bus.resp_fail_o),  SLOT_DW'(efail));
        check("resp_addr",  SLOT_DW'(bus.resp_addr_o),  SLOT_DW'(eaddr));
        check("resp_data",  bus.resp_data_o, edat);
      end
    end
    check("free_cnt", SLOT_DW'(bus.free_cnt_o), SLOT_DW'(m_free_cnt()));
  endtask

  task automatic do_upd(input bit op, input logic [ADDR_W-1:0] a, input logic [SLOT_DW-1:0] d);
    int k; bit wr;
    @(posedge clk); #1;
    bus.upd_valid_i = 1'b1;
    bus.upd_op_i    = {op, a, d};
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.upd_ready_o && k < 20);
    wr = (op == 1'b0) && (int'(a) < N_SLOTS);
    check("upd_ready", SLOT_DW'(bus.upd_ready_o), SLOT_DW'(1));
    check("upd_mem", SLOT_DW'({bus.mem_req_o, bus.mem_we_o}), SLOT_DW'({wr, wr}));
    if (wr) begin
      check("upd_mem_addr", SLOT_DW'(bus.mem_addr_o), SLOT_DW'(a));
      check("upd_mem_wdata", bus.mem_wdata_o, d);
    end
    if (int'(a) < N_SLOTS) begin
      m_bm[int'(a)] = (op == 1'b0);
      if (wr) m_dat[a] = d;
    end
    @(posedge clk); #1;
    bus.upd_valid_i = 1'b0;
    @(negedge clk);
    check("upd_free_cnt", SLOT_DW'(bus.free_cnt_o), SLOT_DW'(m_free_cnt()));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SLOT_DW-1:0] d;
    int lat; bit efail; logic [ADDR_W-1:0] eaddr; logic [SLOT_DW-1:0] edat;
    int k, w;

    for (int i = 0; i < 256; i++) begin
      mem[i]   = '0;
      m_dat[i] = '0;
    end
    m_reset();
    bus.req_valid_i = '0;
    bus.req_op_i    = '0;
    bus.upd_valid_i = 1'b1;              // pending update must be ignored during reset
    bus.upd_op_i    = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_free_cnt",   SLOT_DW'(bus.free_cnt_o),   SLOT_DW'(N_SLOTS));
    check("rst_upd_ready",  SLOT_DW'(bus.upd_ready_o),  '0);
    check("rst_req_ready",  SLOT_DW'(bus.req_ready_o),  '0);
    check("rst_resp_valid", SLOT_DW'(bus.resp_valid_o), '0);
    check("rst_mem_req",    SLOT_DW'(bus.mem_req_o),    '0);
    bus.upd_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // three ALLOCs from requester 0
    for (int i = 0; i < 3; i++) do_req(0, 1'b0, '0);
    check("alloc3_free_cnt", SLOT_DW'(bus.free_cnt_o), SLOT_DW'(13));

    // UPDATE then LOAD hit
    d = {24{8'hA5}};
    do_upd(1'b0, 8'd5, d);
    do_req(1, 1'b1, 8'd5);

    // fill everything, ALLOC when full, FREE 7 and reclaim it
    while (m_first_free() >= 0) do_req(0, 1'b0, '0);
    do_req(0, 1'b0, '0);
    check("full_free_cnt", SLOT_DW'(bus.free_cnt_o), '0);
    do_upd(1'b1, 8'd7, '0);
    do_req(1, 1'b0, '0);
    do_req(0, 1'b1, 8'd7);

    // round robin with both requesters held valid
    do_upd(1'b1, 8'd3, '0);
    do_upd(1'b1, 8'd10, '0);
    @(posedge clk); #1;
    bus.req_op_i    = '0;
    bus.req_valid_i = 2'b11;
    for (int g = 0; g < 4; g++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (bus.req_ready_o == '0 && k < 20);
      w = m_rr;
      check("rr_grant", SLOT_DW'(bus.req_ready_o), SLOT_DW'(1 << w));
      predict(w, 1'b0, '0, lat, efail, eaddr, edat);
      @(negedge clk);
      check("rr_resp_valid", SLOT_DW'(bus.resp_valid_o), SLOT_DW'(1 << w));
      check("rr_resp_addr",  SLOT_DW'(bus.resp_addr_o),  SLOT_DW'(eaddr));
      check("rr_resp_fail",  SLOT_DW'(bus.resp_fail_o),  SLOT_DW'(efail));
    end
    @(posedge clk); #1;
    bus.req_valid_i = '0;

    // update and request in the same IDLE cycle, request is an out-of-range LOAD
    @(posedge clk); #1;
    d = {6{32'h1234_5678}};
    bus.upd_valid_i = 1'b1;
    bus.upd_op_i    = {1'b0, 8'd9, d};
    bus.req_valid_i = 2'b01;
    bus.req_op_i[0 +: OP_W] = {1'b1, 8'd20};
    @(negedge clk);
    check("prio_upd_ready", SLOT_DW'(bus.upd_ready_o), SLOT_DW'(1));
    check("prio_req_ready", SLOT_DW'(bus.req_ready_o), '0);
    m_bm[9] = 1'b1;
    m_dat[9] = d;
    @(posedge clk); #1;
    bus.upd_valid_i = 1'b0;
    @(negedge clk);
    check("prio_req_grant", SLOT_DW'(bus.req_ready_o), SLOT_DW'(1));
    check("prio_no_mem",    SLOT_DW'(bus.mem_req_o),   '0);
    predict(0, 1'b1, 8'd20, lat, efail, eaddr, edat);
    @(posedge clk); #1;
    bus.req_valid_i = '0;
    @(negedge clk);
    check("prio_resp_valid", SLOT_DW'(bus.resp_valid_o), SLOT_DW'(1));
    check("prio_resp_fail",  SLOT_DW'(bus.resp_fail_o),  SLOT_DW'(1));
    check("prio_resp_addr",  SLOT_DW'(bus.resp_addr_o),  SLOT_DW'(20));
    do_req(1, 1'b1, 8'd9);

    // reset while waiting for read data
    @(posedge clk); #1;
    bus.req_valid_i = 2'b01;
    bus.req_op_i[0 +: OP_W] = {1'b1, 8'd9};
    @(negedge clk);
    check("rst6_grant", SLOT_DW'(bus.req_ready_o), SLOT_DW'(1));
    @(posedge clk); #1;
    bus.req_valid_i = '0;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst6_resp_valid", SLOT_DW'(bus.resp_valid_o), '0);
      check("rst6_free_cnt",   SLOT_DW'(bus.free_cnt_o),   SLOT_DW'(N_SLOTS));
      check("rst6_mem_req",    SLOT_DW'(bus.mem_req_o),    '0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    @(negedge clk);
    check("rst6_after_resp", SLOT_DW'(bus.resp_valid_o), '0);
    do_req(1, 1'b0, '0);
    do_req(0, 1'b1, 8'd9);

    // random mix against the model
    for (int n = 0; n < 250; n++) begin
      int sel;
      logic [ADDR_W-1:0] a;
      sel = $urandom_range(0, 3);
      a   = ADDR_W'($urandom_range(0, 19));
      d   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      case (sel)
        0: do_upd(1'b0, a, d);
        1: do_upd(1'b1, a, '0);
        2: do_req($urandom_range(0, N_REQ - 1), 1'b0, '0);
        default: do_req($urandom_range(0, N_REQ - 1), 1'b1, a);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
